miner_job_loader: RTL

Host-side feeder for the mining core: accepts a job packet on a 32-bit valid/ready stream, latches the job registers, pulses the update trigger, and writes the block-header words into the core's message memory one word per cycle. It also returns results: on a valid-nonce pulse from the core, it captures nonce and hash and emits them as a 14-word result packet on a second stream. It sits between the host DMA/AXI-stream bridge and the mining core.

---
 rtl/miner_pkg.sv | 21 ++
 rtl/miner_result_tx.sv | 67 ++++++
 rtl/miner_job_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: FSM encodings and sizes shared by the job loader slice.
// Job FSM, result FSM, descriptor and result word counts.
package miner_pkg;

  typedef enum logic [1:0] {
    DESC,
    TRIG,
    HDR,
    DRAIN
  } job_state_e;

  typedef enum logic {
    RIDLE,
    RSEND
  } res_state_e;

  localparam int DESC_WORDS  = 17;
  localparam int NONCE_BYTES = 24;
  localparam int RES_WORDS   = 14;

endpackage

// File: rtl/miner_result_tx.sv
// miner_result_tx: captures nonce/hash on VldNonce_I, streams 14 words.
// Ports: Clk, Rst_n, VldNonce_I, NonceRes_I, HashRes_I, M_* stream.
module miner_result_tx
  import miner_pkg::*;
(
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            VldNonce_I,
  input  logic [5:0][31:0] NonceRes_I,
  input  logic [7:0][31:0] HashRes_I,
  input  logic            M_Ready_I,
  output logic [31:0]     M_Data_O,
  output logic            M_Valid_O,
  output logic            M_Last_O
);

  localparam logic [3:0] LAST_IDX = 4'(RES_WORDS - 1);

  res_state_e st_q, st_d;
  logic [3:0] idx_q, idx_d;
  logic       cap;
  logic [RES_WORDS-1:0][31:0] res_q;

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    cap   = 1'b0;
    unique case (st_q)
      RIDLE: begin
        if (VldNonce_I) begin
          cap   = 1'b1;
          idx_d = '0;
          st_d  = RSEND;
        end
      end
      RSEND: begin
        if (M_Ready_I) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            st_d  = RIDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: st_d = RIDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q  <= RIDLE;
      idx_q <= '0;
      res_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      // nonce lands in words 0..5, hash in words 6..13
      if (cap) res_q <= {HashRes_I, NonceRes_I};
    end
  end

  assign M_Data_O  = res_q[idx_q];
  assign M_Valid_O = (st_q == RSEND);
  assign M_Last_O  = M_Valid_O && (idx_q == LAST_IDX);

endmodule

// File: rtl/miner_job_loader.sv
// miner_job_loader: loads job descriptor + header words into the core,
// returns nonce/hash results. Ports: S_* job stream, job regs, Wr/Data.
module miner_job_loader
  import miner_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [31:0]      S_Data_I,
  input  logic             S_Valid_I,
  input  logic             S_Last_I,
  output logic             S_Ready_O,
  output logic             UpdateTrigger_O,
  output logic [31:0]      GroupDirections_O,
  output logic [31:0]      Groups_O,
  output logic [31:0]      ChunkLength_O,
  output logic [7:0][31:0] Target_O,
  output logic [5:0][31:0] Nonce_O,
  output logic             Wr_O,
  output logic [31:0]      Data_O,
  input  logic             VldNonce_I,
  input  logic [5:0][31:0] NonceRes_I,
  input  logic [7:0][31:0] HashRes_I,
  output logic [31:0]      M_Data_O,
  output logic             M_Valid_O,
  output logic             M_Last_O,
  input  logic             M_Ready_I,
  output logic             Busy_O,
  output logic             Err_O
);

  localparam logic [31:0] LEN_MIN = 32'(NONCE_BYTES + 4);
  localparam logic [31:0] LEN_MAX =
    32'(NONCE_BYTES + 4 * (2 ** ADDR_WIDTH));
  localparam logic [4:0] LAST_DESC = 5'(DESC_WORDS - 1);

  job_state_e st_q, st_d;
  logic [4:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] hcnt_q, hcnt_d;
  logic err_q, err_d;
  logic rdy_q;
  logic acc, len_bad, desc_we, wr_d;
  logic [DESC_WORDS-1:0][31:0] regs_q;

  assign S_Ready_O = rdy_q && (st_q != TRIG);
  assign acc = S_Valid_I && S_Ready_O;
  assign len_bad = (S_Data_I < LEN_MIN) || (S_Data_I > LEN_MAX)
                || (S_Data_I[1:0] != 2'b00);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    err_d   = err_q;
    desc_we = 1'b0;
    wr_d    = 1'b0;
    unique case (st_q)
      DESC: begin
        if (acc) begin
          if (cnt_q == 5'd0) err_d = 1'b0;
          if (S_Last_I) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            desc_we = 1'b1;
            if (cnt_q == 5'd2 && len_bad) begin
              err_d = 1'b1;
              cnt_d = '0;
              st_d  = DRAIN;
            end else if (cnt_q == LAST_DESC) begin
              cnt_d = '0;
              st_d  = TRIG;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end
      TRIG: begin
        // (len - 28) >> 2 is W-1: counter reaches 0 on the last word
        hcnt_d = ADDR_WIDTH'((ChunkLength_O - LEN_MIN) >> 2);
        st_d   = HDR;
      end
      HDR: begin
        if (acc) begin
          wr_d = 1'b1;
          if (hcnt_q == '0) begin
            if (!S_Last_I) begin
              err_d = 1'b1;
              st_d  = DRAIN;
            end else begin
              st_d = DESC;
            end
          end else begin
            hcnt_d = hcnt_q - ADDR_WIDTH'(1);
            if (S_Last_I) begin
              err_d = 1'b1;
              st_d  = DESC;
            end
          end
        end
      end
      DRAIN: begin
        if (acc && S_Last_I) st_d = DESC;
      end
      default: st_d = DESC;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q   <= DESC;
      cnt_q  <= '0;
      hcnt_q <= '0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b0;
      regs_q <= '0;
      Wr_O   <= 1'b0;
      Data_O <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      hcnt_q <= hcnt_d;
      err_q  <= err_d;
      rdy_q  <= 1'b1;
      Wr_O   <= wr_d;
      if (wr_d) Data_O <= S_Data_I;
      if (desc_we) regs_q[cnt_q] <= S_Data_I;
    end
  end

  assign UpdateTrigger_O   = (st_q == TRIG);
  assign GroupDirections_O = regs_q[0];
  assign Groups_O          = regs_q[1];
  assign ChunkLength_O     = regs_q[2];
  assign Target_O          = regs_q[10:3];
  assign Nonce_O           = regs_q[16:11];
  assign Busy_O            = (st_q != DESC) || (cnt_q != 5'd0);
  assign Err_O             = err_q;

  miner_result_tx u_res (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .VldNonce_I (VldNonce_I),
    .NonceRes_I (NonceRes_I),
    .HashRes_I  (HashRes_I),
    .M_Ready_I  (M_Ready_I),
    .M_Data_O   (M_Data_O),
    .M_Valid_O  (M_Valid_O),
    .M_Last_O   (M_Last_O)
  );

endmodule
